// File: rtl/npu_pkg.sv
// Shared types and constants for the matr-instruction NPU dispatch controller.
package npu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      RETIRE = 2'd3
   } npu_state_t;

   localparam int NPU_ADDR_W = 32;
   localparam int NPU_CNT_W  = 16;

   // Written back instead of a cycle count when the watchdog fires.
   localparam logic [31:0] NPU_TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/npu_busy_counter.sv
// Saturating busy-cycle counter with synchronous clear and enable.
// With NPU_TIMEOUT_EN defined it also flags the cycle whose increment lands on LIMIT.
module npu_busy_counter #(
   parameter int CNT_W = 16,
   parameter int LIMIT = 65535
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count_nxt
`ifdef NPU_TIMEOUT_EN
   ,
   output logic             tc
`endif
);

   localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

   logic [CNT_W-1:0] count;
   logic             at_lim;

   assign at_lim    = (count == LIM);
   assign count_nxt = (en && !at_lim) ? count + CNT_W'(1) : count;

`ifdef NPU_TIMEOUT_EN
   assign tc = en && !at_lim && (count_nxt == LIM);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else
         count <= count_nxt;
   end

endmodule

// File: rtl/npu_dispatch_ctrl.sv
// Launches a matr instruction on the NPU, stalls the front end until ack, then
// writes the busy-cycle count to rd. Optional watchdog: define NPU_TIMEOUT_EN.
module npu_dispatch_ctrl
   import npu_pkg::*;
#(
   parameter int ADDR_W  = NPU_ADDR_W,
   parameter int CNT_W   = NPU_CNT_W,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_matr,
   input  logic [ADDR_W-1:0] id_rs1_data,
   input  logic [ADDR_W-1:0] id_rs2_data,
   input  logic [4:0]        id_rd,
   input  logic              ack,
   output logic              EN_NPU,
   output logic [ADDR_W-1:0] npu_src_addr,
   output logic [ADDR_W-1:0] npu_dst_addr,
   output logic              stall,
   output logic              wb_en,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              npu_err
);

   if (TIMEOUT < 2 || TIMEOUT > (1 << CNT_W) - 1) begin : g_bad_timeout
      $error("npu_dispatch_ctrl: TIMEOUT must lie in [2, 2**CNT_W-1]");
   end

`ifdef NPU_TIMEOUT_EN
   localparam int CNT_LIMIT = TIMEOUT;
   logic cnt_tc;
`else
   localparam int CNT_LIMIT = (1 << CNT_W) - 1;
`endif

   npu_state_t       state;
   logic [4:0]       rd_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic             cnt_clr;
   logic             cnt_en;

   // Stall must assert in the detect cycle itself so the instruction stays in ID.
   assign stall   = (state != IDLE) || id_matr;
   assign cnt_clr = (state == IDLE) && id_matr;
   assign cnt_en  = (state == ISSUE) || (state == WAIT);

   npu_busy_counter #(
      .CNT_W (CNT_W),
      .LIMIT (CNT_LIMIT)
   ) u_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr       (cnt_clr),
      .en        (cnt_en),
      .count_nxt (cnt_nxt)
`ifdef NPU_TIMEOUT_EN
      ,
      .tc        (cnt_tc)
`endif
   );

`ifndef NPU_TIMEOUT_EN
   assign npu_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         EN_NPU       <= 1'b0;
         npu_src_addr <= '0;
         npu_dst_addr <= '0;
         rd_q         <= '0;
         wb_en        <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
`ifdef NPU_TIMEOUT_EN
         npu_err      <= 1'b0;
`endif
      end else begin
         wb_en <= 1'b0;
         case (state)
            IDLE: begin
               if (id_matr) begin
                  npu_src_addr <= id_rs1_data;
                  npu_dst_addr <= id_rs2_data;
                  rd_q         <= id_rd;
                  EN_NPU       <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               // An ack already in the launch cycle counts as a WAIT-state ack.
               if (ack) begin
                  EN_NPU  <= 1'b0;
                  wb_en   <= 1'b1;
                  wb_rd   <= rd_q;
                  wb_data <= 32'(cnt_nxt);
                  state   <= RETIRE;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (ack) begin
                  EN_NPU  <= 1'b0;
                  wb_en   <= 1'b1;
                  wb_rd   <= rd_q;
                  wb_data <= 32'(cnt_nxt);
                  state   <= RETIRE;
               end
`ifdef NPU_TIMEOUT_EN
               else if (cnt_tc) begin
                  EN_NPU  <= 1'b0;
                  npu_err <= 1'b1;
                  wb_en   <= 1'b1;
                  wb_rd   <= rd_q;
                  wb_data <= NPU_TIMEOUT_DATA;
                  state   <= RETIRE;
               end
`endif
            end
            RETIRE: begin
               state <= IDLE;
            end
            default: begin
               EN_NPU <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
